modem_symbol_framer: RTL and testbench
======================================

MODEM_SYMBOL_FRAMER -- requirements
Module: modem_symbol_framer

Interface
REQ-001 Parameter CLKS_PER_SYM, default 16, clock cycles per transmitted symbol (legal range 2..256).
REQ-002 Parameter PREAMBLE_SYMS, default 4, preamble symbols sent before each data byte (legal range 1..16).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design enable; low freezes all state.
REQ-006 sel  input  2  modulation mode: 00 ASK, 01 FSK, 10 BPSK, 11 QPSK.
REQ-007 din  input  8  byte to transmit.
REQ-008 din_valid  input  1  din holds a valid byte.
REQ-009 din_ready  output  1  framer accepts a byte this cycle.
REQ-010 sym  output  2  current symbol to the downstream modulator.
REQ-011 sym_stb  output  1  one-cycle pulse on the first cycle of every symbol.
REQ-012 tx_active  output  1  high while a frame is in progress.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, PREAMBLE, DATA, STOP.
REQ-014 din_ready SHALL equal ena AND (state == IDLE), combinationally.
REQ-015 A transfer SHALL occur on a clock edge where din_valid, din_ready and ena are all high; din and sel are latched and the FSM enters PREAMBLE.
REQ-016 The latched mode SHALL govern the entire frame; sel changes mid-frame SHALL be ignored.
REQ-017 din_valid with din_ready low SHALL be ignored and SHALL NOT be queued.
REQ-018 The first symbol SHALL start on the cycle after the transfer: sym_stb = 1 on that cycle.
REQ-019 Each symbol SHALL hold sym constant for exactly CLKS_PER_SYM enabled cycles.
REQ-020 sym_stb SHALL be high only on the first enabled cycle of each symbol.
REQ-021 PREAMBLE SHALL send PREAMBLE_SYMS symbols in an alternating pattern, starting with the "on" symbol:
- ASK/FSK/BPSK: sym = 01, 00, 01, ...
- QPSK: sym = 11, 00, 11, ...
REQ-022 DATA SHALL send the latched byte LSB first:
- ASK/FSK/BPSK: 8 symbols, sym = {0, bit}.
- QPSK: 4 symbols, sym = din[1:0], din[3:2], din[5:4], din[7:6].
REQ-023 STOP SHALL send one symbol with sym = 00, then return to IDLE.
REQ-024 In IDLE: sym = 00, sym_stb = 0, tx_active = 0.
REQ-025 tx_active SHALL be high in PREAMBLE, DATA and STOP.
REQ-026 Frame length SHALL be (PREAMBLE_SYMS + N + 1) * CLKS_PER_SYM cycles, with N = 8 for 1-bit modes and N = 4 for QPSK.
REQ-027 While ena = 0:
- all counters, shift register and FSM state SHALL hold;
- sym SHALL hold;
- sym_stb SHALL be 0.
REQ-028 A sym_stb pending when ena falls SHALL be issued on the first cycle ena returns high.
REQ-029 The symbol counter SHALL wrap from CLKS_PER_SYM-1 to 0, and symbol indices SHALL never exceed the count for the current state.
REQ-030 The next byte SHALL be accepted no earlier than the first IDLE cycle after STOP; frames never overlap.

Reset
REQ-031 While rst_n = 0, all of the following SHALL be forced asynchronously:
- FSM = IDLE;
- sym = 00, sym_stb = 0, tx_active = 0;
- counters and shift register = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no STOP symbol.
REQ-033 On the first edge after rst_n rises, with ena = 1, din_ready SHALL be 1.

Verification
REQ-034 BPSK:
- Stimulus: sel = 10, din = 0xA5, one-cycle valid.
- Response: sym_stb pulses every 16 cycles; sym sequence 01,00,01,00, 01,00,01,00,00,01,00,01, 00; tx_active high for 208 cycles.
REQ-035 QPSK:
- Stimulus: sel = 11, din = 0x1B.
- Response: preamble 11,00,11,00; data 11,10,01,00; stop 00; frame 144 cycles.
REQ-036 sel change and repeated valid mid-frame:
- Stimulus: sel toggled from 10 to 11 mid-frame; din_valid held high with new data.
- Response: frame unchanged; second byte accepted on the first IDLE cycle.
REQ-037 ena pause:
- Stimulus: ena low for 5 cycles during DATA symbol 3.
- Response: no sym_stb during the gap; symbol 3 extended by exactly 5 cycles; total frame 213 cycles.
REQ-038 Reset mid-frame:
- Stimulus: rst_n pulsed low during PREAMBLE.
- Response: sym = 00, tx_active = 0 immediately; din_ready = 1 after release.

Source files
------------

// File: rtl/modem_symbol_framer_if.sv
// -----------------------------------------------------------------------------
// modem_symbol_framer_if
//
// Purpose: groups the byte-input handshake and the symbol-output bus of
// modem_symbol_framer so the framer and its driver share one bundle.
//
// Signals:
//   ena        design enable; low freezes the framer
//   sel[1:0]   modulation mode: 00 ASK, 01 FSK, 10 BPSK, 11 QPSK
//   din[7:0]   byte to transmit
//   din_valid  din holds a valid byte
//   din_ready  framer accepts a byte this cycle
//   sym[1:0]   current symbol to the downstream modulator
//   sym_stb    one-cycle pulse on the first enabled cycle of every symbol
//   tx_active  high while a frame is in progress
//
// Handshake: a byte moves on a rising edge where din_valid, din_ready and ena
// are all high. din_ready is a pure combinational function of ena and the
// framer state, so it never depends on din_valid. A valid byte that is not
// accepted is simply dropped by the framer; nothing is queued, and the source
// must keep din_valid high (with stable din/sel) until it sees the transfer.
// -----------------------------------------------------------------------------
interface modem_symbol_framer_if;

    logic       ena;
    logic [1:0] sel;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] sym;
    logic       sym_stb;
    logic       tx_active;

    // Framer side.
    modport slave (
        input  ena,
        input  sel,
        input  din,
        input  din_valid,
        output din_ready,
        output sym,
        output sym_stb,
        output tx_active
    );

    // Source / modulator side.
    modport master (
        output ena,
        output sel,
        output din,
        output din_valid,
        input  din_ready,
        input  sym,
        input  sym_stb,
        input  tx_active
    );

endinterface

// File: rtl/modem_symbol_framer.sv
// -----------------------------------------------------------------------------
// modem_symbol_framer
//
// Purpose: takes one byte at a time and emits a frame of 2-bit symbols for a
// downstream modulator:
//   PREAMBLE : PREAMBLE_SYMS alternating symbols, starting with the "on"
//              symbol (01 for ASK/FSK/BPSK, 11 for QPSK)
//   DATA     : the byte LSB first, 8 one-bit symbols {0,bit} or, for QPSK,
//              4 dibit symbols din[1:0], din[3:2], din[5:4], din[7:6]
//   STOP     : one 00 symbol, then back to IDLE
// Every symbol lasts CLKS_PER_SYM enabled cycles; sym_stb marks its first
// enabled cycle. The mode is latched with the byte and governs the frame.
//
// Parameters:
//   CLKS_PER_SYM   clock cycles per symbol (2..256)
//   PREAMBLE_SYMS  preamble symbols per frame (1..16)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          modem_symbol_framer_if.slave (ena, sel, din, din_valid,
//                din_ready, sym, sym_stb, tx_active)
//   dbg_state_o  FSM state: 0 IDLE, 1 PREAMBLE, 2 DATA, 3 STOP
// -----------------------------------------------------------------------------
module modem_symbol_framer #(
    parameter int CLKS_PER_SYM  = 16,
    parameter int PREAMBLE_SYMS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    modem_symbol_framer_if.slave  bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_STOP     = 2'd3
    } state_t;

    localparam int             CW       = (CLKS_PER_SYM > 2) ? $clog2(CLKS_PER_SYM) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_SYM - 1);
    localparam logic [3:0]     PRE_LAST = 4'(PREAMBLE_SYMS - 1);
    localparam logic [1:0]     MODE_QPSK = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;     // cycle within the current symbol
    logic [3:0]     idx_q,   idx_d;     // symbol index within the current state
    logic [7:0]     shift_q, shift_d;   // remaining data bits, LSB next
    logic [1:0]     mode_q,  mode_d;    // modulation mode latched with the byte
    logic [1:0]     sym_q,   sym_d;
    // A new symbol has been loaded but its strobe has not been issued yet.
    // Holding it as state (rather than deriving it from cnt_q == 0) lets a
    // strobe that falls in an ena-low gap come out on the first enabled cycle.
    logic           pend_q,  pend_d;

    // -------------------------------------------------------------------------
    // Mode-dependent helpers
    // -------------------------------------------------------------------------
    logic           is_qpsk;
    logic [1:0]     on_sym;
    logic [1:0]     data_sym;
    logic [7:0]     shift_next;
    logic [3:0]     data_last;
    logic           sym_end;

    always_comb begin
        is_qpsk    = (mode_q == MODE_QPSK);
        on_sym     = is_qpsk ? 2'b11 : 2'b01;
        data_sym   = is_qpsk ? shift_q[1:0] : {1'b0, shift_q[0]};
        shift_next = is_qpsk ? {2'b00, shift_q[7:2]} : {1'b0, shift_q[7:1]};
        data_last  = is_qpsk ? 4'd3 : 4'd7;
        sym_end    = (cnt_q == CNT_LAST);
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Every register defaults to hold, and nothing moves
    // unless ena is high, which gives the freeze-on-ena-low behaviour for free.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        mode_d  = mode_q;
        sym_d   = sym_q;
        pend_d  = pend_q;

        if (bus.ena) begin
            if (state_q == ST_IDLE) begin
                if (bus.din_valid) begin
                    state_d = ST_PREAMBLE;
                    mode_d  = bus.sel;
                    shift_d = bus.din;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    sym_d   = (bus.sel == MODE_QPSK) ? 2'b11 : 2'b01;
                    pend_d  = 1'b1;
                end
            end else begin
                // The strobe (if pending) is issued on this enabled cycle.
                pend_d = 1'b0;
                if (!sym_end) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // Last cycle of a symbol: load the following one.
                    cnt_d  = '0;
                    pend_d = 1'b1;
                    case (state_q)
                        ST_PREAMBLE: begin
                            if (idx_q == PRE_LAST) begin
                                state_d = ST_DATA;
                                idx_d   = 4'd0;
                                sym_d   = data_sym;
                                shift_d = shift_next;
                            end else begin
                                idx_d = idx_q + 4'd1;
                                // Even indices carry the "on" symbol.
                                sym_d = idx_q[0] ? on_sym : 2'b00;
                            end
                        end
                        ST_DATA: begin
                            if (idx_q == data_last) begin
                                state_d = ST_STOP;
                                idx_d   = 4'd0;
                                sym_d   = 2'b00;
                            end else begin
                                idx_d   = idx_q + 4'd1;
                                sym_d   = data_sym;
                                shift_d = shift_next;
                            end
                        end
                        default: begin
                            // End of STOP: back to IDLE with a quiet output.
                            state_d = ST_IDLE;
                            idx_d   = 4'd0;
                            shift_d = 8'h00;
                            sym_d   = 2'b00;
                            pend_d  = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            shift_q <= 8'h00;
            mode_q  <= 2'b00;
            sym_q   <= 2'b00;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            mode_q  <= mode_d;
            sym_q   <= sym_d;
            pend_q  <= pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.din_ready = bus.ena && (state_q == ST_IDLE);
    assign bus.sym       = sym_q;
    assign bus.sym_stb   = bus.ena && pend_q;
    assign bus.tx_active = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_modem_symbol_framer.sv
module tb_modem_symbol_framer;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    modem_symbol_framer_if bus ();

    modem_symbol_framer #(
        .CLKS_PER_SYM (16),
        .PREAMBLE_SYMS(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    logic [1:0] cap_sym[$];
    int         cap_cyc[$];
    int         cap_len;
    int         cap_hold_err;
    int         cap_ready_err;
    int         cap_pause_stb;
    bit         cap_timeout;

    // ---------------------------------------------------------------- drivers
    task automatic start_frame(input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        bus.ena       = 1'b1;
        bus.sel       = s;
        bus.din       = d;
        bus.din_valid = 1'b1;
        #1;
    endtask

    // Samples one frame on falling edges (cycle k = 1 is the cycle after the
    // transfer edge) until tx_active drops. Optionally pauses ena for cycles
    // pause_at .. pause_at+pause_len-1 and changes sel at cycle sel_at.
    task automatic collect(input int budget, input int pause_at, input int pause_len,
                           input int sel_at, input logic [1:0] new_sel, input bit hold_valid);
        int k;
        bit seen;
        bit done;
        logic [1:0] last_sym;
        logic [1:0] prev_sym;
        k = 0; seen = 0; done = 0; last_sym = 2'b00; prev_sym = bus.sym;
        cap_sym.delete(); cap_cyc.delete();
        cap_len = 0; cap_hold_err = 0; cap_ready_err = 0; cap_pause_stb = 0; cap_timeout = 0;
        while (!done) begin
            @(negedge clk);
            k++;
            if (bus.sym_stb === 1'b1) begin
                cap_sym.push_back(bus.sym);
                cap_cyc.push_back(k);
                last_sym = bus.sym;
                if (!bus.ena) cap_pause_stb++;
            end else if (bus.ena && bus.tx_active && bus.sym !== last_sym) begin
                cap_hold_err++;
            end
            if (!bus.ena && bus.sym !== prev_sym) cap_hold_err++;
            if (bus.tx_active === 1'b1) begin
                seen = 1;
                cap_len++;
                if (bus.din_ready !== 1'b0) cap_ready_err++;
            end else if (seen) begin
                done = 1;
            end
            if (k >= budget) begin
                cap_timeout = 1;
                done = 1;
            end
            prev_sym = bus.sym;
            if (!hold_valid) bus.din_valid = 1'b0;
            bus.ena = !((k + 1) >= pause_at && (k + 1) < pause_at + pause_len);
            if (k + 1 == sel_at) bus.sel = new_sel;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        bus.ena = 1'b1; bus.sel = 2'b00; bus.din = 8'h00; bus.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.sym !== 2'b00 || bus.sym_stb !== 1'b0 || bus.tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got sym=%b stb=%b act=%b want 00/0/0", bus.sym, bus.sym_stb, bus.tx_active);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.din_ready !== 1'b1 || bus.tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b act=%b want 1/0", bus.din_ready, bus.tx_active);
        end
    endtask

    task automatic test_bpsk;
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                  2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        start_frame(2'b10, 8'hA5);
        n_checks++;
        if (bus.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL bpsk_ready got %b want 1", bus.din_ready);
        end
        collect(400, 0, 0, 0, 2'b10, 1'b0);
        n_checks++;
        if (cap_timeout || cap_len != 208) begin
            n_fail++; $display("FAIL bpsk_len got %0d (timeout=%0d) want 208", cap_len, cap_timeout);
        end
        n_checks++;
        if (cap_sym.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bpsk_count got %0d want %0d", cap_sym.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bpsk_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
        for (int i = 0; i < cap_cyc.size(); i++) begin
            n_checks++;
            if (cap_cyc[i] != 1 + 16 * i) begin
                n_fail++; $display("FAIL bpsk_stb_cycle[%0d] got %0d want %0d", i, cap_cyc[i], 1 + 16 * i);
            end
        end
        n_checks++;
        if (cap_hold_err != 0 || cap_ready_err != 0) begin
            n_fail++; $display("FAIL bpsk_hold_ready got hold=%0d ready=%0d want 0/0", cap_hold_err, cap_ready_err);
        end
        n_checks++;
        if (bus.sym !== 2'b00 || bus.din_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL bpsk_idle got sym=%b ready=%b st=%0d want 00/1/0", bus.sym, bus.din_ready, dbg_state);
        end
    endtask

    task automatic test_qpsk;
        exp_q = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        start_frame(2'b11, 8'h1B);
        collect(400, 0, 0, 0, 2'b11, 1'b0);
        n_checks++;
        if (cap_timeout || cap_len != 144) begin
            n_fail++; $display("FAIL qpsk_len got %0d (timeout=%0d) want 144", cap_len, cap_timeout);
        end
        n_checks++;
        if (cap_sym.size() != exp_q.size()) begin
            n_fail++; $display("FAIL qpsk_count got %0d want %0d", cap_sym.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL qpsk_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
        n_checks++;
        if (cap_hold_err != 0) begin
            n_fail++; $display("FAIL qpsk_hold got %0d want 0", cap_hold_err);
        end
    endtask

    task automatic test_one_bit_modes;
        // ASK 0x0F: data 1,1,1,1,0,0,0,0
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01,
                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        start_frame(2'b00, 8'h0F);
        collect(400, 0, 0, 0, 2'b00, 1'b0);
        n_checks++;
        if (cap_len != 208 || cap_sym.size() != 13) begin
            n_fail++; $display("FAIL ask_shape got len=%0d syms=%0d want 208/13", cap_len, cap_sym.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL ask_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
        // FSK 0x80: data 0,0,0,0,0,0,0,1
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                  2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        start_frame(2'b01, 8'h80);
        collect(400, 0, 0, 0, 2'b01, 1'b0);
        n_checks++;
        if (cap_len != 208 || cap_sym.size() != 13) begin
            n_fail++; $display("FAIL fsk_shape got len=%0d syms=%0d want 208/13", cap_len, cap_sym.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fsk_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sel_change_back_to_back;
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                  2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        start_frame(2'b10, 8'hA5);
        @(posedge clk);
        #1;
        bus.din = 8'h3C;            // new byte offered, valid stays high
        collect(400, 0, 0, 40, 2'b11, 1'b1);
        n_checks++;
        if (cap_len != 208 || cap_sym.size() != 13) begin
            n_fail++; $display("FAIL selchg_shape got len=%0d syms=%0d want 208/13", cap_len, cap_sym.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL selchg_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
        n_checks++;
        if (cap_ready_err != 0) begin
            n_fail++; $display("FAIL selchg_ready_midframe got %0d want 0", cap_ready_err);
        end
        n_checks++;
        if (bus.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL selchg_first_idle_ready got %b want 1", bus.din_ready);
        end
        // Second byte 0x3C in QPSK: data 00,11,11,00.
        exp_q = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
        collect(400, 0, 0, 0, 2'b11, 1'b0);
        n_checks++;
        if (cap_cyc.size() == 0 || cap_cyc[0] != 1 || cap_len != 144) begin
            n_fail++; $display("FAIL b2b_start got first_stb=%0d len=%0d want 1/144",
                               (cap_cyc.size() != 0) ? cap_cyc[0] : -1, cap_len);
        end
        for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
            n_checks++;
            if (cap_sym[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_sym[%0d] got %b want %b", i, cap_sym[i], exp_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.tx_active !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_queue got act=%b want 0", bus.tx_active);
        end
    endtask

    task automatic test_ena_pause;
        int starts[2];
        starts[0] = 118;            // inside DATA symbol 3 (starts at cycle 113)
        starts[1] = 129;            // exactly on the DATA symbol 4 strobe cycle
        exp_q = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                  2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        for (int t = 0; t < 2; t++) begin
            start_frame(2'b10, 8'hA5);
            collect(400, starts[t], 5, 0, 2'b10, 1'b0);
            n_checks++;
            if (cap_timeout || cap_len != 213) begin
                n_fail++; $display("FAIL pause%0d_len got %0d want 213", t, cap_len);
            end
            n_checks++;
            if (cap_pause_stb != 0 || cap_hold_err != 0) begin
                n_fail++; $display("FAIL pause%0d_quiet got stb=%0d hold=%0d want 0/0", t, cap_pause_stb, cap_hold_err);
            end
            for (int i = 0; i < exp_q.size() && i < cap_sym.size(); i++) begin
                n_checks++;
                if (cap_sym[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL pause%0d_sym[%0d] got %b want %b", t, i, cap_sym[i], exp_q[i]);
                end
            end
            for (int i = 1; i < cap_cyc.size(); i++) begin
                n_checks++;
                if (cap_cyc[i] - cap_cyc[i-1] != ((i == 8) ? 21 : 16)) begin
                    n_fail++; $display("FAIL pause%0d_gap[%0d] got %0d want %0d", t, i,
                                       cap_cyc[i] - cap_cyc[i-1], (i == 8) ? 21 : 16);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        start_frame(2'b10, 8'hA5);
        @(negedge clk);
        bus.din_valid = 1'b0;
        repeat (19) @(negedge clk);
        n_checks++;
        if (bus.tx_active !== 1'b1 || dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL rstmid_pre got act=%b st=%0d want 1/1", bus.tx_active, dbg_state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.sym !== 2'b00 || bus.tx_active !== 1'b0 || bus.sym_stb !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort got sym=%b act=%b stb=%b want 00/0/0", bus.sym, bus.tx_active, bus.sym_stb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.din_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_release got ready=%b st=%0d want 1/0", bus.din_ready, dbg_state);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (bus.tx_active !== 1'b0 || bus.sym !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_no_stop got act=%b sym=%b want 0/00", bus.tx_active, bus.sym);
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset;
        test_bpsk;
        test_qpsk;
        test_one_bit_modes;
        test_sel_change_back_to_back;
        test_ena_pause;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
